// File: rtl/lipsi_mem_arbiter_if.sv
// Bus bundle between the Lipsi core, the host port and the memory macro.
interface lipsi_mem_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 8
);
   logic              core_req;
   logic              core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic              core_gnt;
   logic              core_rvalid;
   logic [DATA_W-1:0] core_rdata;

   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_gnt;
   logic              host_rvalid;
   logic [DATA_W-1:0] host_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      input  host_req, host_we, host_addr, host_wdata,
      input  mem_rdata,
      output core_gnt, core_rvalid, core_rdata,
      output host_gnt, host_rvalid, host_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata,
      output host_req, host_we, host_addr, host_wdata,
      output mem_rdata,
      input  core_gnt, core_rvalid, core_rdata,
      input  host_gnt, host_rvalid, host_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lipsi_mem_arbiter.sv
// Core-priority arbiter for the shared Lipsi memory port.
// Define LIPSI_ARB_FAIR_EN to enable the host starvation counter.
module lipsi_mem_arbiter #(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 8,
   parameter int MAX_WAIT = 4
) (
   input logic               clk,
   input logic               reset1,
   lipsi_mem_arbiter_if.slave bus
);

   if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_wait
      $error("MAX_WAIT out of range 1..15");
   end

   logic              host_win;
   logic              core_win;
   logic [1:0]        rd_owner_q;
   logic [1:0]        rd_owner_d;
   logic              mem_we_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_d;

`ifdef LIPSI_ARB_FAIR_EN
   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   logic [3:0] wait_cnt_q;
   logic [3:0] wait_cnt_d;

   // Host takes a contested cycle once it has lost WAIT_MAX in a row.
   always_comb begin
      host_win = bus.host_req &
                 (~bus.core_req | (wait_cnt_q == WAIT_MAX));
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (host_win) begin
         wait_cnt_d = '0;
      end else if (bus.host_req && wait_cnt_q != WAIT_MAX) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset1) begin
      if (!reset1) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end
`else
   always_comb begin
      host_win = bus.host_req & ~bus.core_req;
   end
`endif

   always_comb begin
      core_win = bus.core_req & ~host_win;
   end

   always_comb begin
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      unique case (1'b1)
         core_win: begin
            mem_we_d    = bus.core_we;
            mem_addr_d  = bus.core_addr;
            mem_wdata_d = bus.core_wdata;
         end
         host_win: begin
            mem_we_d    = bus.host_we;
            mem_addr_d  = bus.host_addr;
            mem_wdata_d = bus.host_wdata;
         end
         default: begin
            mem_we_d    = 1'b0;
         end
      endcase
   end

   always_comb begin
      rd_owner_d = {host_win & ~bus.host_we, core_win & ~bus.core_we};
   end

   always_ff @(posedge clk or negedge reset1) begin
      if (!reset1) begin
         rd_owner_q <= '0;
      end else begin
         rd_owner_q <= rd_owner_d;
      end
   end

   assign bus.core_gnt    = core_win;
   assign bus.host_gnt    = host_win;
   assign bus.mem_en      = core_win | host_win;
   assign bus.mem_we      = mem_we_d;
   assign bus.mem_addr    = mem_addr_d;
   assign bus.mem_wdata   = mem_wdata_d;
   assign bus.core_rvalid = rd_owner_q[0];
   assign bus.host_rvalid = rd_owner_q[1];
   assign bus.core_rdata  = bus.mem_rdata;
   assign bus.host_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_lipsi_mem_arbiter.sv
// Bench for lipsi_mem_arbiter: memory model, reference model, directed vectors.
module tb_lipsi_mem_arbiter;
   localparam int AW = 9;
   localparam int DW = 8;
   localparam int MW = 4;
`ifdef LIPSI_ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset1 = 1'b0;
   always #5 clk = ~clk;

   lipsi_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   lipsi_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk   (clk),
      .reset1(reset1),
      .bus   (bus)
   );

   // Memory macro: 512 x 8, synchronous read
   logic [7:0] mem [512];
   logic [7:0] mrd = 8'h00;
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else mrd <= mem[bus.mem_addr];
      end
   end
   assign bus.mem_rdata = mrd;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: shadow memory, consecutive host losses, pending read
   logic [7:0] sh [512];
   int         losses = 0;
   int         nlosses = 0;
   bit         pc = 0, ph = 0, nc = 0, nh = 0, nw = 0;
   logic [7:0] pd = 8'h00, nd = 8'h00, nwd = 8'h00;
   logic [8:0] nwa = 9'h0;

   always @(negedge clk) begin
      bit eh, ec, ewe;
      logic [8:0] ea;
      logic [7:0] ed;
      eh  = bus.host_req && (!bus.core_req || (FAIR && losses >= MW));
      ec  = bus.core_req && !eh;
      ewe = ec ? bus.core_we : (eh ? bus.host_we : 1'b0);
      ea  = ec ? bus.core_addr : (eh ? bus.host_addr : 9'h0);
      ed  = ec ? bus.core_wdata : (eh ? bus.host_wdata : 8'h0);
      chk("core_gnt", 32'(bus.core_gnt), 32'(ec));
      chk("host_gnt", 32'(bus.host_gnt), 32'(eh));
      chk("mem_en", 32'(bus.mem_en), 32'(ec || eh));
      chk("mem_we", 32'(bus.mem_we), 32'(ewe));
      chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(ed));
      chk("core_rvalid", 32'(bus.core_rvalid), 32'(pc && reset1));
      chk("host_rvalid", 32'(bus.host_rvalid), 32'(ph && reset1));
      if (reset1 && pc) chk("core_rdata", 32'(bus.core_rdata), 32'(pd));
      if (reset1 && ph) chk("host_rdata", 32'(bus.host_rdata), 32'(pd));
      if (!reset1) begin
         nc = 0; nh = 0; nw = 0; nlosses = 0;
      end else begin
         nc  = ec && !ewe;
         nh  = eh && !ewe;
         nd  = sh[ea];
         nw  = (ec || eh) && ewe;
         nwa = ea;
         nwd = ed;
         if (eh) nlosses = 0;
         else if (bus.host_req) nlosses = (losses + 1 > MW) ? MW : losses + 1;
         else nlosses = losses;
      end
   end

   always @(posedge clk) begin
      if (nw) sh[nwa] <= nwd;
      pc     <= nc;
      ph     <= nh;
      pd     <= nd;
      losses <= nlosses;
   end

   task automatic idle();
      bus.core_req = 0; bus.core_we = 0;
      bus.core_addr = '0; bus.core_wdata = '0;
      bus.host_req = 0; bus.host_we = 0;
      bus.host_addr = '0; bus.host_wdata = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int hq[$];
   int both;

   initial begin
      for (int i = 0; i < 512; i++) begin
         mem[i] <= 8'(i) ^ 8'h5A;
         sh[i]  <= 8'(i) ^ 8'h5A;
      end
      mem[16] <= 8'hA5;
      sh[16]  <= 8'hA5;
      idle();
      // Pending core read held during reset
      bus.core_req = 1; bus.core_addr = 9'h010;
      step(); step();
      @(negedge clk);
      chk("rst_core_rvalid", 32'(bus.core_rvalid), 0);
      chk("rst_host_rvalid", 32'(bus.host_rvalid), 0);
      idle();
      step();
      reset1 = 1;
      step();
      // Core-only read
      bus.core_req = 1; bus.core_addr = 9'h010;
      @(negedge clk);
      chk("core_gnt_lit", 32'(bus.core_gnt), 1);
      chk("mem_addr_lit", 32'(bus.mem_addr), 32'h010);
      step();
      idle();
      @(negedge clk);
      chk("core_rvalid_lit", 32'(bus.core_rvalid), 1);
      chk("core_rdata_lit", 32'(bus.core_rdata), 32'hA5);
      step();
      // Reset while a read return is outstanding
      bus.core_req = 1; bus.core_addr = 9'h010;
      step();
      idle();
      #1 reset1 = 0;
      #1 chk("midrst_rvalid", 32'(bus.core_rvalid), 0);
      @(negedge clk);
      #2 reset1 = 1;
      step();
      // Host write then read-back
      bus.host_req = 1; bus.host_we = 1;
      bus.host_addr = 9'h1FF; bus.host_wdata = 8'h3C;
      @(negedge clk);
      chk("host_wr_gnt", 32'(bus.host_gnt), 1);
      step();
      bus.host_we = 0;
      @(negedge clk);
      chk("host_rd_gnt", 32'(bus.host_gnt), 1);
      chk("wr_no_rvalid", 32'(bus.host_rvalid), 0);
      step();
      idle();
      @(negedge clk);
      chk("host_rvalid_lit", 32'(bus.host_rvalid), 1);
      chk("host_rdata_lit", 32'(bus.host_rdata), 32'h3C);
      step();
      // Contention: both read continuously for 50 cycles
      bus.core_req = 1; bus.core_addr = 9'h001;
      bus.host_req = 1; bus.host_addr = 9'h002;
      both = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.host_gnt) hq.push_back(i);
         if (bus.core_rvalid && bus.host_rvalid) both++;
         step();
      end
`ifdef LIPSI_ARB_FAIR_EN
      chk("host_win_1st", 32'(hq.size() > 0 ? hq[0] : -1), 4);
      chk("host_win_2nd", 32'(hq.size() > 1 ? hq[1] : -1), 9);
`else
      chk("strict_host_gnts", 32'(hq.size()), 0);
`endif
      chk("both_rvalid", 32'(both), 0);
      // Mixed traffic on a small address window
      for (int i = 0; i < 200; i++) begin
         bus.core_req   = 1'($urandom_range(0, 1));
         bus.core_we    = ($urandom_range(0, 3) == 0);
         bus.core_addr  = 9'($urandom_range(0, 15));
         bus.core_wdata = 8'($urandom);
         bus.host_req   = 1'($urandom_range(0, 1));
         bus.host_we    = ($urandom_range(0, 3) == 0);
         bus.host_addr  = 9'($urandom_range(0, 15));
         bus.host_wdata = 8'($urandom);
         step();
      end
      idle();
      step();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/lipsi_mem_arbiter.md
# lipsi_mem_arbiter

Single-port memory arbiter sharing the Lipsi program/data memory (512 x 8, synchronous read, 1-cycle latency) between the Lipsi core and an external host port used for program load and debug readback. It sits between the core's memory interface and the memory macro inside the top level. Core access has priority, and a starvation counter guarantees the host forward progress.

## Interface
- ADDR_W, 9, memory address width
- DATA_W, 8, memory data width
- MAX_WAIT, 4, contested cycles the host may lose in a row before it wins; legal range 1..15
- clk  input  1  system clock, rising edge
- reset1  input  1  asynchronous, active-low reset
- core_req  input  1  core requests an access this cycle
- core_we  input  1  1 = write, 0 = read
- core_addr  input  ADDR_W  core address
- core_wdata  input  DATA_W  core write data
- core_gnt  output  1  core access issued this cycle; core stalls while core_req=1 and core_gnt=0
- core_rvalid  output  1  core read data valid, one cycle after a granted read
- core_rdata  output  DATA_W  read data, equal to mem_rdata
- host_req, host_we, host_addr, host_wdata  input  1/1/ADDR_W/DATA_W  host request, same meaning as the core signals
- host_gnt, host_rvalid, host_rdata  output  1/1/DATA_W  host grant and read return, same meaning as the core signals
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0

## Operation
- Grant logic is combinational from the requests and the registered starvation state. At most one grant is active per cycle.
- Only core_req: core_gnt=1. Only host_req: host_gnt=1. Neither: no grant, mem_en=0.
- Both requesting (contested):
  - core wins unless wait_cnt == MAX_WAIT, in which case host wins.
- wait_cnt (4-bit register):
  - +1 on each cycle with host_req=1 and host_gnt=0, saturating at MAX_WAIT.
  - cleared on any cycle with host_gnt=1.
  - held otherwise.
- Memory port follows the winner: mem_en=1, and mem_we/addr/wdata are the winner's. With no grant, mem_en=0, mem_we=0, and mem_addr/mem_wdata=0.
- Read return: registered rd_owner[1:0] (bit 0 core, bit 1 host) is set to the grant of the cycle when it is a read, and cleared otherwise.
  - core_rvalid = rd_owner[0]; host_rvalid = rd_owner[1].
  - core_rdata = host_rdata = mem_rdata, unqualified.
- A granted write produces no rvalid.
- A requester that loses keeps its request and fields stable until granted. Changing them while ungranted is permitted and simply re-arbitrates.

## Timing
- Grant and the memory strobe occur in the same cycle as the request (0-cycle arbitration). Read latency is 1 cycle after grant.
- Back-to-back grants are allowed every cycle. A read in cycle N and a write in cycle N+1 from different owners are legal.
- Reset (reset1=0, asynchronous) clears wait_cnt=0 and rd_owner=0, so core_rvalid=0 and host_rvalid=0 immediately.
  - Grants and mem_* outputs are combinational and follow requests even during reset. The top holds requesters idle during reset.
- Reset mid-read: the pending rvalid is dropped and the data is lost. The requester must reissue.
- Worst-case host latency with core_req held high continuously is MAX_WAIT+1 cycles from host_req assertion to host_gnt.

## Configuration
- LIPSI_ARB_FAIR_EN defined: starvation counter active as described.
- LIPSI_ARB_FAIR_EN undefined: strict core priority. wait_cnt is not implemented and the host can be starved indefinitely. All other behaviour is identical.

## Test plan
- Reset: reset1=0 with core_req=1 pending read -> core_rvalid=0 and host_rvalid=0 immediately. After release, wait_cnt=0.
- Core only: core read at addr 9'h010 with mem holding 8'hA5 -> core_gnt in same cycle, mem_addr=9'h010, core_rvalid=1 and core_rdata=8'hA5 next cycle.
- Host only: host write addr 9'h1FF data 8'h3C, then host read of 9'h1FF -> two grants in consecutive cycles, host_rvalid=1 with 8'h3C after the read, no rvalid after the write.
- Contention, MAX_WAIT=4, fair build: core_req and host_req held high -> core granted cycles 0-3, host granted cycle 4, core cycles 5-8, host cycle 9.
- Contention, strict build (LIPSI_ARB_FAIR_EN undefined): same stimulus for 50 cycles -> host_gnt never asserted.
- Simultaneous reads core@9'h001 and host@9'h002 alternating with fairness forced -> every rvalid goes to exactly the owner granted in the prior cycle, never both.
